// File: rtl/nexys_starship_pkg.sv
// Shared encodings for the Nexys Starship monster controller: global game
// states, per-station occupancy and the spawn LFSR polynomial.
package nexys_starship_pkg;

   typedef enum logic [2:0] {
      INIT = 3'b001,
      PLAY = 3'b010,
      OVER = 3'b100
   } game_state_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } station_state_t;

   localparam int                LFSR_W    = 16;
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

   // Right-shifting Galois step; the shifted-out bit folds the taps back in.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
      return {1'b0, v[LFSR_W-1:1]} ^ (v[0] ? LFSR_TAPS : '0);
   endfunction

endpackage

// File: rtl/nexys_starship_station.sv
// One monster station: EMPTY/FULL occupancy plus its shoot-timeout timer.
// A shot on a FULL station always beats both expiry and a same-cycle spawn.
module nexys_starship_station
   import nexys_starship_pkg::*;
#(
   parameter int TIMEOUT = 200_000_000,
   parameter int TIMER_W = 28
) (
   input  logic Clk,
   input  logic Reset,
   input  logic clear,
   input  logic spawn,
   input  logic shot,
   input  logic run,
   input  logic freeze,
   output logic full,
   output logic expire
);

   station_state_t     st, st_n;
   logic [TIMER_W-1:0] timer, timer_n;
   logic               act;

   assign act    = run & ~freeze;
   assign full   = (st == FULL);
   assign expire = act & full & (timer == '0) & ~shot;

   always_comb begin
      st_n    = st;
      timer_n = timer;
      if (clear) begin
         st_n    = EMPTY;
         timer_n = '0;
      end else if (act) begin
         if (st == FULL) begin
            if (shot) begin
               st_n    = EMPTY;
               timer_n = '0;
            end else if (timer != '0) begin
               timer_n = timer - 1'b1;
            end
         end else if (spawn) begin
            st_n    = FULL;
            timer_n = TIMER_W'(TIMEOUT - 1);
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         st    <= EMPTY;
         timer <= '0;
      end else begin
         st    <= st_n;
         timer <= timer_n;
      end
   end

endmodule

// File: rtl/nexys_starship_monsters.sv
// Monster controller top: global INIT/PLAY/OVER FSM, LFSR-driven spawner,
// saturating kill score and an array of independent station timers.
module nexys_starship_monsters
   import nexys_starship_pkg::*;
#(
   parameter int              NUM_STATIONS = 4,
   parameter int              TIMEOUT      = 200_000_000,
   parameter int              TIMER_W      = 28,
   parameter int              SPAWN_PERIOD = 100_000_000,
   parameter int              SCORE_W      = 8,
   parameter logic [LFSR_W-1:0] SEED       = 16'hACE1
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    play,
   input  logic [NUM_STATIONS-1:0] shot,
   output logic                    q_Init,
   output logic                    q_Play,
   output logic                    q_Over,
   output logic [NUM_STATIONS-1:0] monster,
   output logic                    game_over,
   output logic [SCORE_W-1:0]      score
);

   localparam int IDX_W = (NUM_STATIONS > 1) ? $clog2(NUM_STATIONS) : 1;
   localparam int CNT_W = $clog2(SPAWN_PERIOD);
   localparam int SUM_W = SCORE_W + 5;

   game_state_t             state, state_n;
   logic                    start;
   logic [CNT_W-1:0]        spawn_cnt;
   logic                    tick;
   logic [LFSR_W-1:0]       lfsr;
   logic [IDX_W-1:0]        idx;
   logic [NUM_STATIONS-1:0] spawn_vec;
   logic [NUM_STATIONS-1:0] expire;
   logic [4:0]              kills;
   logic [SUM_W-1:0]        score_sum;
   logic [SCORE_W-1:0]      score_n;

   assign q_Init    = state[0];
   assign q_Play    = state[1];
   assign q_Over    = state[2];
   assign game_over = q_Over;

   always_comb begin
      state_n = state;
      start   = 1'b0;
      case (state)
         INIT: if (play) begin
            state_n = PLAY;
            start   = 1'b1;
         end
         PLAY: if (|expire) state_n = OVER;
         OVER: if (play) state_n = INIT;
         default: state_n = INIT;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) state <= INIT;
      else        state <= state_n;
   end

   assign tick = q_Play && (spawn_cnt == CNT_W'(SPAWN_PERIOD - 1));

   always_ff @(posedge Clk) begin
      if (!Reset)      spawn_cnt <= '0;
      else if (start)  spawn_cnt <= '0;
      else if (q_Play) spawn_cnt <= tick ? '0 : spawn_cnt + 1'b1;
   end

   // Free-running so the candidate index depends on when the player starts.
   always_ff @(posedge Clk) begin
      if (!Reset) lfsr <= SEED;
      else        lfsr <= lfsr_step(lfsr);
   end

   assign idx = (NUM_STATIONS > 1) ? lfsr[IDX_W-1:0] : '0;

   // Out-of-range indices match nothing, so such ticks are simply lost.
   always_comb begin
      spawn_vec = '0;
      for (int i = 0; i < NUM_STATIONS; i++)
         spawn_vec[i] = tick && (idx == IDX_W'(i));
   end

   for (genvar i = 0; i < NUM_STATIONS; i++) begin : g_st
      nexys_starship_station #(
         .TIMEOUT (TIMEOUT),
         .TIMER_W (TIMER_W)
      ) u_station (
         .Clk    (Clk),
         .Reset  (Reset),
         .clear  (start),
         .spawn  (spawn_vec[i]),
         .shot   (shot[i]),
         .run    (q_Play),
         .freeze (q_Over),
         .full   (monster[i]),
         .expire (expire[i])
      );
   end

   always_comb begin
      kills = '0;
      for (int i = 0; i < NUM_STATIONS; i++)
         kills = kills + 5'(shot[i] & monster[i]);
   end

   assign score_sum = SUM_W'(score) + SUM_W'(kills);
   assign score_n   = (score_sum > SUM_W'({SCORE_W{1'b1}})) ? '1 : score_sum[SCORE_W-1:0];

   always_ff @(posedge Clk) begin
      if (!Reset)      score <= '0;
      else if (start)  score <= '0;
      else if (q_Play) score <= score_n;
   end

endmodule

// File: tb/tb_nexys_starship_monsters.sv
// Bench for the monster controller: a 4-station / 2-bit-score instance and a
// 3-station instance, each shadowed by a cycle-level game model.
module tb_nexys_starship_monsters;

   localparam int T  = 10;
   localparam int SP = 5;
   localparam logic [2:0] SI = 3'b100, SPL = 3'b010, SO = 3'b001;

   logic       Clk = 1'b0;
   logic       Reset, play_a, play_b;
   logic [3:0] shot_a;
   logic [2:0] shot_b;
   logic       q_Init_a, q_Play_a, q_Over_a, game_over_a;
   logic       q_Init_b, q_Play_b, q_Over_b, game_over_b;
   logic [3:0] monster_a;
   logic [2:0] monster_b;
   logic [1:0] score_a;
   logic [7:0] score_b;

   always #5 Clk = ~Clk;

   nexys_starship_monsters #(.NUM_STATIONS(4), .TIMEOUT(T), .TIMER_W(8), .SPAWN_PERIOD(SP),
                             .SCORE_W(2), .SEED(16'hACE1)) u_a (
      .Clk(Clk), .Reset(Reset), .play(play_a), .shot(shot_a),
      .q_Init(q_Init_a), .q_Play(q_Play_a), .q_Over(q_Over_a),
      .monster(monster_a), .game_over(game_over_a), .score(score_a));

   nexys_starship_monsters #(.NUM_STATIONS(3), .TIMEOUT(T), .TIMER_W(8), .SPAWN_PERIOD(SP),
                             .SCORE_W(8), .SEED(16'h1234)) u_b (
      .Clk(Clk), .Reset(Reset), .play(play_b), .shot(shot_b),
      .q_Init(q_Init_b), .q_Play(q_Play_b), .q_Over(q_Over_b),
      .monster(monster_b), .game_over(game_over_b), .score(score_b));

   int checks = 0, errors = 0;

   // Game model, index 0 = u_a, 1 = u_b. Game states: 0 init, 1 play, 2 over.
   int          m_st[2], m_cnt[2], m_score[2];
   bit          m_full[2][4];
   int          m_tmr[2][4];
   logic [15:0] m_lfsr[2];
   int          b_ticks = 0;

   typedef struct {
      int al; bit rst; bit pl; logic [3:0] sh;
      logic [2:0] st; logic [3:0] mon; logic [3:0] mm; int sc;
   } vec_t;
   vec_t tbl[$];

   function automatic logic [15:0] gal(logic [15:0] v);
      return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic int idx_at(logic [15:0] v, int steps);
      for (int j = 0; j < steps; j++) v = gal(v);
      return int'(v[1:0]);
   endfunction

   function automatic int nst(int k);  return (k == 0) ? 4 : 3;   endfunction
   function automatic int smax(int k); return (k == 0) ? 3 : 255; endfunction
   function automatic logic [15:0] seed(int k); return (k == 0) ? 16'hACE1 : 16'h1234; endfunction

   function automatic logic [3:0] st_vec(int s);
      return (s == 0) ? 4'b1000 : (s == 1) ? 4'b0100 : 4'b0011;
   endfunction

   function automatic logic [3:0] mfull(int k);
      logic [3:0] r = '0;
      for (int i = 0; i < 4; i++) r[i] = m_full[k][i];
      return r;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic fail_bound(string nm);
      checks++;
      errors++;
      $display("FAIL %s wait bound expired", nm);
   endtask

   task automatic step(int k, bit rst, bit pl, logic [3:0] sh);
      int n = nst(k), idx, kills;
      bit tick, ex;
      if (!rst) begin
         m_st[k] = 0; m_cnt[k] = 0; m_score[k] = 0; m_lfsr[k] = seed(k);
         for (int i = 0; i < 4; i++) begin m_full[k][i] = 0; m_tmr[k][i] = 0; end
         return;
      end
      idx = int'(m_lfsr[k]) % (1 << $clog2(n));
      case (m_st[k])
         0: if (pl) begin
            m_st[k] = 1; m_cnt[k] = 0; m_score[k] = 0;
            for (int i = 0; i < 4; i++) begin m_full[k][i] = 0; m_tmr[k][i] = 0; end
         end
         1: begin
            tick = (m_cnt[k] == SP - 1);
            m_cnt[k] = tick ? 0 : m_cnt[k] + 1;
            if (tick && k == 1) b_ticks++;
            kills = 0; ex = 0;
            for (int i = 0; i < n; i++) begin
               if (m_full[k][i]) begin
                  if (sh[i]) begin kills++; m_full[k][i] = 0; end
                  else if (m_tmr[k][i] == 0) ex = 1;
                  else m_tmr[k][i]--;
               end else if (tick && idx == i) begin
                  m_full[k][i] = 1; m_tmr[k][i] = T - 1;
               end
            end
            m_score[k] = (m_score[k] + kills > smax(k)) ? smax(k) : m_score[k] + kills;
            if (ex) m_st[k] = 2;
         end
         default: if (pl) m_st[k] = 0;
      endcase
      m_lfsr[k] = gal(m_lfsr[k]);
   endtask

   task automatic cycle();
      @(posedge Clk);
      step(0, Reset, play_a, shot_a);
      step(1, Reset, play_b, {1'b0, shot_b});
      #1;
      chk("a_state", {q_Init_a, q_Play_a, q_Over_a, game_over_a}, st_vec(m_st[0]));
      chk("a_monster", monster_a, mfull(0));
      chk("a_score", score_a, m_score[0]);
      chk("b_state", {q_Init_b, q_Play_b, q_Over_b, game_over_b}, st_vec(m_st[1]));
      chk("b_monster", {1'b0, monster_b}, mfull(1));
      chk("b_score", score_b, m_score[1]);
      chk("b_no_x", 32'($isunknown({q_Init_b, q_Play_b, q_Over_b, game_over_b, monster_b, score_b})), 0);
   endtask

   task automatic addr(int rep, int al, bit rst, bit pl, logic [3:0] sh,
                       logic [2:0] st, logic [3:0] mon, logic [3:0] mm, int sc);
      vec_t v;
      for (int r = 0; r < rep; r++) begin
         v.al = (r == 0) ? al : 0; v.rst = rst; v.pl = pl; v.sh = sh;
         v.st = st; v.mon = mon; v.mm = mm; v.sc = sc;
         tbl.push_back(v);
      end
   endtask

   int n, kills;

   initial begin
      // Game over after an unshot monster, then frozen through OVER and INIT.
      addr(1, 1, 1, 1, 0, SPL, 0, 4'b0100, 0);
      addr(4, 0, 1, 0, 0, SPL, 0, 4'b0100, 0);
      addr(10, 0, 1, 0, 0, SPL, 4'b0100, 4'b0100, 0);
      addr(2, 0, 1, 0, 0, SO, 4'b0100, 4'b0100, 0);
      addr(1, 0, 1, 0, 4'b0100, SO, 4'b0100, 4'b0100, 0);
      addr(1, 0, 1, 1, 0, SI, 4'b0100, 4'b0100, 0);
      addr(1, 0, 1, 0, 0, SI, 4'b0100, 4'b0100, 0);
      // Kill three cycles after spawn, then mid-game reset clears the score.
      addr(1, 1, 1, 1, 0, SPL, 0, 4'hF, 0);
      addr(4, 0, 1, 0, 0, SPL, 0, 4'b0100, 0);
      addr(3, 0, 1, 0, 0, SPL, 4'b0100, 4'b0100, 0);
      addr(1, 0, 1, 0, 4'b0100, SPL, 0, 4'b0100, 1);
      addr(1, 0, 1, 0, 0, SPL, 0, 4'b0100, 1);
      addr(3, 0, 0, 0, 0, SI, 0, 4'hF, 0);
      addr(1, 0, 1, 0, 0, SI, 0, 4'hF, 0);
      // Shot on the expiring cycle wins; that cycle's spawn tick on station 2 is lost.
      addr(1, 2, 1, 1, 0, SPL, 0, 4'hF, 0);
      addr(4, 0, 1, 0, 0, SPL, 0, 4'b0100, 0);
      addr(10, 0, 1, 0, 0, SPL, 4'b0100, 4'b0100, 0);
      addr(1, 0, 1, 0, 4'b0100, SPL, 0, 4'b0100, 1);
      addr(4, 0, 1, 0, 0, SPL, 0, 4'b0100, 1);
      addr(1, 0, 0, 0, 0, SI, 0, 4'hF, 0);
      addr(1, 0, 1, 0, 0, SI, 0, 4'hF, 0);
      // Reset held three cycles mid-game with a monster present.
      addr(1, 1, 1, 1, 0, SPL, 0, 4'hF, 0);
      addr(4, 0, 1, 0, 0, SPL, 0, 4'b0100, 0);
      addr(2, 0, 1, 0, 0, SPL, 4'b0100, 4'b0100, 0);
      addr(3, 0, 0, 0, 0, SI, 0, 4'hF, 0);
      addr(1, 0, 1, 0, 0, SI, 0, 4'hF, 0);

      Reset = 1'b0; play_a = 1'b0; play_b = 1'b0; shot_a = '0; shot_b = '0;
      repeat (3) cycle();
      chk("rst_q_init", q_Init_a, 1);
      chk("rst_score", score_a, 0);
      Reset = 1'b1;

      foreach (tbl[j]) begin
         if (tbl[j].al != 0) begin
            n = 0;
            while (n < 3000 && !(m_st[0] == 0 && idx_at(m_lfsr[0], 5) == 2 &&
                                 (tbl[j].al == 1 || idx_at(m_lfsr[0], 15) == 2))) begin
               cycle();
               n++;
            end
            if (n >= 3000) fail_bound("tbl_align");
         end
         Reset = tbl[j].rst; play_a = tbl[j].pl; shot_a = tbl[j].sh;
         cycle();
         chk($sformatf("tbl%0d_state", j), {q_Init_a, q_Play_a, q_Over_a}, tbl[j].st);
         chk($sformatf("tbl%0d_monster", j), monster_a & tbl[j].mm, tbl[j].mon & tbl[j].mm);
         chk($sformatf("tbl%0d_score", j), score_a, tbl[j].sc);
         Reset = 1'b1; play_a = 1'b0; shot_a = '0;
      end

      // Five kills on a 2-bit score saturate at 3; then OVER -> INIT -> PLAY.
      play_a = 1'b1;
      cycle();
      play_a = 1'b0;
      kills = 0; n = 0;
      while (kills < 5 && n < 1000) begin
         for (int i = 0; i < 4; i++) shot_a[i] = m_full[0][i];
         for (int i = 0; i < 4; i++) kills += int'(shot_a[i]);
         cycle();
         n++;
      end
      shot_a = '0;
      if (kills < 5) fail_bound("sat_kills");
      else chk("sat_score", score_a, 3);
      n = 0;
      while (!q_Over_a && n < 200) begin cycle(); n++; end
      chk("reach_over", q_Over_a, 1);
      chk("over_score", score_a, 3);
      play_a = 1'b1; cycle(); play_a = 1'b0;
      chk("over_to_init", {q_Init_a, q_Play_a, q_Over_a}, SI);
      cycle();
      chk("init_hold", {q_Init_a, q_Play_a, q_Over_a}, SI);
      play_a = 1'b1; cycle(); play_a = 1'b0;
      chk("init_to_play", {q_Init_a, q_Play_a, q_Over_a}, SPL);
      chk("score_cleared", score_a, 0);

      // Random play on both; u_b runs until it has seen 1000 spawn ticks.
      for (int c = 0; c < 20000 && b_ticks < 1000; c++) begin
         Reset  = ($urandom_range(0, 999) != 0);
         play_a = ($urandom_range(0, 15) == 0);
         for (int i = 0; i < 4; i++) shot_a[i] = ($urandom_range(0, 7) == 0);
         play_b = (m_st[1] != 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
         for (int i = 0; i < 3; i++)
            shot_b[i] = m_full[1][i] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
         cycle();
      end
      if (b_ticks < 1000) fail_bound("b_ticks");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
